// File: rtl/led_pulse_stretcher_pkg.sv
// Shared front-panel package: blink FSM state encoding and default timing.
package led_pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } led_state_e;

    // 50 ms on / 50 ms off at 100 MHz.
    localparam int unsigned LED_ON_CYCLES_DEF  = 5_000_000;
    localparam int unsigned LED_GAP_CYCLES_DEF = 5_000_000;
    localparam int unsigned LED_CNT_W_DEF      = 23;
    localparam int unsigned LED_PEND_W_DEF     = 4;

endpackage

// File: rtl/led_pulse_stretcher.sv
// Stretches one-cycle event strobes into visible LED blinks. Every blink is
// an ON period followed by a mandatory GAP. Events that arrive during a blink
// are queued in a saturating pending counter. Events lost to saturation
// produce a one-cycle drop pulse.
module led_pulse_stretcher
    import led_pulse_stretcher_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = LED_ON_CYCLES_DEF,
    parameter int unsigned GAP_CYCLES = LED_GAP_CYCLES_DEF,
    parameter int unsigned CNT_W      = LED_CNT_W_DEF,
    parameter int unsigned PEND_W     = LED_PEND_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              event_in,
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              drop
);

    localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES);
    localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    led_state_e        state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [PEND_W-1:0] pend_q,  pend_d;
    logic              drop_q,  drop_d;
    logic              led_q,   busy_q;
    logic              terminal;

    // A timer of 0 inside ON/GAP is unreachable, but it is treated as
    // terminal so the counter can never wrap.
    assign terminal = (timer_q <= CNT_ONE);

    // Next-state, timer, pending-queue and drop logic.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pend_d  = pend_q;
        drop_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (event_in) begin
                    state_d = ST_ON;
                    timer_d = ON_LOAD;
                end
            end
            ST_ON: begin
                if (terminal) begin
                    state_d = ST_GAP;
                    timer_d = GAP_LOAD;
                end else begin
                    timer_d = timer_q - CNT_ONE;
                end
                if (event_in) begin
                    if (pend_q == PEND_MAX) drop_d = 1'b1;
                    else                    pend_d = pend_q + PEND_ONE;
                end
            end
            ST_GAP: begin
                if (terminal) begin
                    // eff = pending + event_in; eff-1 reduces to pending when
                    // the event is consumed here, else pending-1. The event
                    // is never dropped on this cycle.
                    if (event_in || (pend_q != '0)) begin
                        state_d = ST_ON;
                        timer_d = ON_LOAD;
                        pend_d  = event_in ? pend_q : (pend_q - PEND_ONE);
                    end else begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end
                end else begin
                    timer_d = timer_q - CNT_ONE;
                    if (event_in) begin
                        if (pend_q == PEND_MAX) drop_d = 1'b1;
                        else                    pend_d = pend_q + PEND_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
                pend_d  = '0;
            end
        endcase
    end

    // State and registered outputs; reset overrides any event in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            pend_q  <= '0;
            drop_q  <= 1'b0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            led_q   <= (state_d == ST_ON);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign led     = led_q;
    assign busy    = busy_q;
    assign pending = pend_q;
    assign drop    = drop_q;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Testbench for led_pulse_stretcher: directed scenarios plus random traffic
// against a timeline-based reference model.
module tb_led_pulse_stretcher;

    localparam int ON   = 4;
    localparam int GAP  = 3;
    localparam int PW   = 2;
    localparam int CW   = 3;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          event_in;
    logic          led;
    logic          busy;
    logic [PW-1:0] pending;
    logic          drop;

    always #5 clk = ~clk;

    led_pulse_stretcher #(
        .ON_CYCLES (ON),
        .GAP_CYCLES(GAP),
        .CNT_W     (CW),
        .PEND_W    (PW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .event_in(event_in),
        .led     (led),
        .busy    (busy),
        .pending (pending),
        .drop    (drop)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // The model describes the current blink by the edge it started on.
    // The LED is lit for the ON cycles following that edge. It is dark for
    // the GAP cycles after those.
    int edge_n  = 0;
    bit m_active;
    int m_start;
    int m_pend;
    bit m_drop;
    int m_drops;

    // Statistics per scenario, observed on the DUT.
    int dut_blinks;
    int dut_drops;
    int max_pend;
    bit prev_led;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_edge(input bit ev, input bit r);
        m_drop = 1'b0;
        if (r) begin
            m_active = 1'b0;
            m_pend   = 0;
        end else if (!m_active) begin
            if (ev) begin
                m_active = 1'b1;
                m_start  = edge_n;
            end
        end else if (edge_n == m_start + ON + GAP) begin
            if (m_pend + int'(ev) > 0) begin
                m_pend  = m_pend + int'(ev) - 1;
                m_start = edge_n;
            end else begin
                m_active = 1'b0;
            end
        end else if (ev) begin
            if (m_pend < PMAX) begin
                m_pend++;
            end else begin
                m_drop = 1'b1;
                m_drops++;
            end
        end
    endtask

    task automatic step(input bit ev, input bit r);
        bit exp_led;
        event_in = ev;
        rst      = r;
        @(posedge clk);
        model_edge(ev, r);
        #1;
        exp_led = m_active && ((edge_n + 1 - m_start) <= ON);
        check_eq("led",     32'(led),     32'(exp_led));
        check_eq("busy",    32'(busy),    32'(m_active));
        check_eq("pending", 32'(pending), 32'(m_pend));
        check_eq("drop",    32'(drop),    32'(m_drop));
        if (led && !prev_led) dut_blinks++;
        if (drop) dut_drops++;
        if (int'(pending) > max_pend) max_pend = int'(pending);
        prev_led = led;
        edge_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    // Reset, then clear the per-scenario statistics.
    task automatic scen_begin();
        step(1'b0, 1'b1);
        dut_blinks = 0;
        dut_drops  = 0;
        max_pend   = 0;
        m_drops    = 0;
    endtask

    initial begin
        int events;
        rst      = 1'b1;
        event_in = 1'b0;
        m_active = 1'b0;
        m_pend   = 0;
        m_start  = 0;
        m_drops  = 0;
        prev_led = 1'b0;

        // Single event.
        scen_begin();
        step(1'b1, 1'b0);
        idle(12);
        check_eq("single_blinks", 32'(dut_blinks), 32'd1);
        check_eq("single_maxpend", 32'(max_pend), 32'd0);

        // Events at edges 0 and 2: back-to-back blinks.
        scen_begin();
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
        idle(16);
        check_eq("two_blinks", 32'(dut_blinks), 32'd2);
        check_eq("two_maxpend", 32'(max_pend), 32'd1);

        // Second event exactly on the GAP terminal edge 7.
        scen_begin();
        step(1'b1, 1'b0);
        idle(6);
        step(1'b1, 1'b0);
        idle(10);
        check_eq("term_blinks", 32'(dut_blinks), 32'd2);
        check_eq("term_maxpend", 32'(max_pend), 32'd0);

        // Saturation: events on edges 0..4.
        scen_begin();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        idle(32);
        check_eq("sat_blinks", 32'(dut_blinks), 32'd4);
        check_eq("sat_drops", 32'(dut_drops), 32'd1);
        check_eq("sat_maxpend", 32'(max_pend), 32'(PMAX));

        // Saturated pending with an event on the GAP terminal edge: no drop.
        scen_begin();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        idle(3);
        step(1'b1, 1'b0);
        idle(40);
        check_eq("satterm_blinks", 32'(dut_blinks), 32'd5);
        check_eq("satterm_drops", 32'(dut_drops), 32'd0);

        // Reset during ON abandons everything.
        scen_begin();
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        idle(15);
        check_eq("rst_blinks", 32'(dut_blinks), 32'd1);

        // Reset and event together.
        scen_begin();
        idle(10);
        step(1'b1, 1'b1);
        idle(10);
        check_eq("rstev_blinks", 32'(dut_blinks), 32'd0);

        // Random traffic with occasional reset.
        scen_begin();
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 99) == 0));

        // Random events without reset: each event becomes a blink or a drop.
        scen_begin();
        events = 0;
        for (int i = 0; i < 400; i++) begin
            bit ev;
            ev = ($urandom_range(0, 3) == 0);
            if (ev) events++;
            step(ev, 1'b0);
        end
        for (int i = 0; i < 200 && m_active; i++) step(1'b0, 1'b0);
        check_eq("drain_idle", 32'(busy), 32'd0);
        check_eq("conserve_blinks", 32'(dut_blinks), 32'(events - m_drops));
        check_eq("conserve_drops", 32'(dut_drops), 32'(m_drops));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
